// File: rtl/miriscv_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// miriscv_data_mem_arbiter
//
// Shares the single data memory port between two masters:
//   port 0 - core LSU (memory / mem-data stages)
//   port 1 - secondary master (debug / DMA)
//
// Round-robin arbitration with one transaction in flight at a time. The
// winner's request fields are captured in IDLE and replayed on data_* in REQ
// until memory grants. The response is routed back to the owning port. A
// watchdog forces an error response if memory never answers.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   mN_req/we/be/addr/wdata request from port N (held until mN_gnt_o)
//   mN_gnt_o                request accepted by memory
//   mN_rvalid/rdata/err     one-cycle response pulse to the owner
//   data_req/we/be/addr/wdata  memory request side
//   data_gnt_i, data_rvalid_i, data_rdata_i  memory handshake/response
// ---------------------------------------------------------------------------
module miriscv_data_mem_arbiter #(
    parameter int XLEN        = 32,
    parameter int RSP_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [XLEN/8-1:0] m0_be_i,
    input  logic [XLEN-1:0]   m0_addr_i,
    input  logic [XLEN-1:0]   m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [XLEN-1:0]   m0_rdata_o,
    output logic              m0_err_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [XLEN/8-1:0] m1_be_i,
    input  logic [XLEN-1:0]   m1_addr_i,
    input  logic [XLEN-1:0]   m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [XLEN-1:0]   m1_rdata_o,
    output logic              m1_err_o,

    output logic              data_req_o,
    output logic              data_we_o,
    output logic [XLEN/8-1:0] data_be_o,
    output logic [XLEN-1:0]   data_addr_o,
    output logic [XLEN-1:0]   data_wdata_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic [XLEN-1:0]   data_rdata_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    // Counter value on the last cycle of WAIT_RSP before the forced error.
    localparam logic [CNT_W-1:0] TO_LAST =
        (RSP_TIMEOUT == 0) ? '0 : CNT_W'(RSP_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    logic                we_q, we_d;
    logic [XLEN/8-1:0]   be_q, be_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Response to the current owner, valid for this cycle only.
    logic                rsp_fire;
    logic                rsp_err;
    logic [XLEN-1:0]     rsp_data;
    logic                sel;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rsp_fire     = 1'b0;
        rsp_err      = 1'b0;
        rsp_data     = '0;
        sel          = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    // On a tie the port that did not win last time goes first.
                    sel     = (m0_req_i && m1_req_i) ? ~last_owner_q : m1_req_i;
                    owner_d = sel;
                    we_d    = sel ? m1_we_i    : m0_we_i;
                    be_d    = sel ? m1_be_i    : m0_be_i;
                    addr_d  = sel ? m1_addr_i  : m0_addr_i;
                    wdata_d = sel ? m1_wdata_i : m0_wdata_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    last_owner_d = owner_q;
                    if (data_rvalid_i) begin
                        // Zero-latency memory: grant and response together.
                        rsp_fire = 1'b1;
                        rsp_data = data_rdata_i;
                        state_d  = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (data_rvalid_i) begin
                    rsp_fire = 1'b1;
                    rsp_data = data_rdata_i;
                    state_d  = IDLE;
                end else if (RSP_TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
        end
    end

    assign data_req_o   = (state_q == REQ);
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;

    assign m0_gnt_o    = data_req_o && data_gnt_i && !owner_q;
    assign m1_gnt_o    = data_req_o && data_gnt_i &&  owner_q;

    assign m0_rvalid_o = rsp_fire && !owner_q;
    assign m1_rvalid_o = rsp_fire &&  owner_q;
    assign m0_err_o    = rsp_err  && !owner_q;
    assign m1_err_o    = rsp_err  &&  owner_q;
    assign m0_rdata_o  = (rsp_fire && !owner_q) ? rsp_data : '0;
    assign m1_rdata_o  = (rsp_fire &&  owner_q) ? rsp_data : '0;

endmodule

// File: tb/tb_miriscv_data_mem_arbiter.sv
module tb_miriscv_data_mem_arbiter;
    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [3:0]        m0_be_i, m1_be_i, data_be_o;
    logic [XLEN-1:0]   m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic              m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic              m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [XLEN-1:0]   m0_rdata_o, m1_rdata_o;
    logic              data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
    logic [XLEN-1:0]   data_addr_o, data_wdata_o, data_rdata_i;

    always #5 clk = ~clk;

    miriscv_data_mem_arbiter #(.XLEN(XLEN), .RSP_TIMEOUT(4), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i)
    );

    typedef struct {
        logic            port;
        logic [XLEN-1:0] data;
        logic            err;
    } rsp_t;

    typedef struct {
        logic            port;
        logic [XLEN-1:0] addr;
    } gnt_t;

    rsp_t rsp_q[$];
    gnt_t gnt_q[$];
    int   npass = 0;
    int   ntot  = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_i = 0; m0_we_i = 0; m0_be_i = '0; m0_addr_i = '0; m0_wdata_i = '0;
        m1_req_i = 0; m1_we_i = 0; m1_be_i = '0; m1_addr_i = '0; m1_wdata_i = '0;
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Scoreboard side: compare every grant and response at the falling edge.
    rsp_t er;
    gnt_t eg;
    always @(negedge clk) begin
        if (m0_rvalid_o || m1_rvalid_o) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                er = rsp_q.pop_front();
                chk("rsp_both", {31'd0, m0_rvalid_o && m1_rvalid_o}, 0);
                chk("rsp_port", {31'd0, m1_rvalid_o}, {31'd0, er.port});
                chk("rsp_data", er.port ? m1_rdata_o : m0_rdata_o, er.data);
                chk("rsp_err", {31'd0, er.port ? m1_err_o : m0_err_o}, {31'd0, er.err});
                chk("rsp_other_data", er.port ? m0_rdata_o : m1_rdata_o, 0);
            end
        end
        if (m0_gnt_o || m1_gnt_o) begin
            if (gnt_q.size() == 0) chk("gnt_unexpected", 1, 0);
            else begin
                eg = gnt_q.pop_front();
                chk("gnt_both", {31'd0, m0_gnt_o && m1_gnt_o}, 0);
                chk("gnt_port", {31'd0, m1_gnt_o}, {31'd0, eg.port});
                chk("gnt_addr", data_addr_o, eg.addr);
            end
        end
    end

    initial begin
        int req_cycles;
        logic p;
        do_reset();

        // Reset state: everything quiet.
        #3;
        chk("rst_data_req", {31'd0, data_req_o}, 0);
        chk("rst_gnt", {30'd0, m1_gnt_o, m0_gnt_o}, 0);
        chk("rst_rvalid", {30'd0, m1_rvalid_o, m0_rvalid_o}, 0);
        chk("rst_addr", data_addr_o, 0);
        chk("rst_rdata", m0_rdata_o | m1_rdata_o, 0);
        tick();

        // Single port-0 read, rvalid two cycles after the grant.
        m0_req_i = 1; m0_addr_i = 32'h100; m0_be_i = 4'hf;
        #3 chk("t1_idle_no_req", {31'd0, data_req_o}, 0);
        chk("t1_idle_no_gnt", {31'd0, m0_gnt_o}, 0);
        tick();
        data_gnt_i = 1;
        gnt_q.push_back('{port: 1'b0, addr: 32'h100});
        #3 chk("t1_req", {31'd0, data_req_o}, 1);
        chk("t1_m1_gnt", {31'd0, m1_gnt_o}, 0);
        tick();
        m0_req_i = 0; data_gnt_i = 0;
        #3 chk("t1_wait_no_req", {31'd0, data_req_o}, 0);
        tick();
        data_rvalid_i = 1; data_rdata_i = 32'hDEADBEEF;
        rsp_q.push_back('{port: 1'b0, data: 32'hDEADBEEF, err: 1'b0});
        #3 chk("t1_m1_rvalid", {31'd0, m1_rvalid_o}, 0);
        tick();
        data_rvalid_i = 0;

        // Both ports requesting from reset: grants alternate 0,1,0,1.
        do_reset();
        m0_we_i = 1; m0_be_i = 4'h3; m0_addr_i = 32'h2000; m0_wdata_i = 32'h11112222;
        m1_we_i = 0; m1_be_i = 4'hc; m1_addr_i = 32'h3000; m1_wdata_i = 32'h33334444;
        for (int k = 0; k < 4; k++) begin
            p = k[0];
            m0_req_i = 1; m1_req_i = 1; data_gnt_i = 0; data_rvalid_i = 0;
            tick();
            data_gnt_i = 1;
            gnt_q.push_back('{port: p, addr: p ? 32'h3000 : 32'h2000});
            #3 chk("t2_we", {31'd0, data_we_o}, p ? 0 : 1);
            chk("t2_be", {28'd0, data_be_o}, p ? 32'hc : 32'h3);
            chk("t2_wdata", data_wdata_o, p ? 32'h33334444 : 32'h11112222);
            tick();
            data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'hA0000000 + k;
            rsp_q.push_back('{port: p, data: 32'hA0000000 + k, err: 1'b0});
            tick();
        end

        // Memory stalls the grant for 5 cycles; no re-arbitration.
        m0_req_i = 0; m1_req_i = 1; m1_addr_i = 32'h4444; data_rvalid_i = 0;
        tick();
        req_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) m0_req_i = 1;
            #3;
            if (data_req_o) req_cycles++;
            chk("t3_addr_stable", data_addr_o, 32'h4444);
            chk("t3_no_gnt", {30'd0, m1_gnt_o, m0_gnt_o}, 0);
            tick();
        end
        data_gnt_i = 1;
        gnt_q.push_back('{port: 1'b1, addr: 32'h4444});
        #3 if (data_req_o) req_cycles++;
        chk("t3_req_cycles", req_cycles, 6);
        tick();
        m0_req_i = 0; m1_req_i = 0; data_gnt_i = 0;
        data_rvalid_i = 1; data_rdata_i = 32'h55;
        rsp_q.push_back('{port: 1'b1, data: 32'h55, err: 1'b0});
        tick();
        data_rvalid_i = 0;

        // Watchdog: grant, no response, error after 4 WAIT_RSP cycles.
        m0_req_i = 1; m0_addr_i = 32'h6000;
        tick();
        data_gnt_i = 1;
        gnt_q.push_back('{port: 1'b0, addr: 32'h6000});
        tick();
        m0_req_i = 0; data_gnt_i = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) rsp_q.push_back('{port: 1'b0, data: '0, err: 1'b1});
            #3 if (c < 3) chk("t4_no_early_rsp", {31'd0, m0_rvalid_o}, 0);
            tick();
        end
        // Late response in IDLE goes nowhere.
        data_rvalid_i = 1; data_rdata_i = 32'hBAD;
        #3 chk("t4_late_rsp", {30'd0, m1_rvalid_o, m0_rvalid_o}, 0);
        chk("t4_late_rdata", m0_rdata_o | m1_rdata_o, 0);
        tick();
        data_rvalid_i = 0;

        // Grant and response in the same cycle.
        m1_req_i = 1; m1_addr_i = 32'h7000;
        tick();
        data_gnt_i = 1; data_rvalid_i = 1; data_rdata_i = 32'h12345678;
        gnt_q.push_back('{port: 1'b1, addr: 32'h7000});
        rsp_q.push_back('{port: 1'b1, data: 32'h12345678, err: 1'b0});
        #3 chk("t5_gnt_and_rvalid", {30'd0, m1_gnt_o, m1_rvalid_o}, 3);
        tick();
        m1_req_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
        #3 chk("t5_back_idle", {31'd0, data_req_o}, 0);
        tick();

        // Reset during WAIT_RSP.
        m1_req_i = 1; m1_addr_i = 32'h8000;
        tick();
        data_gnt_i = 1;
        gnt_q.push_back('{port: 1'b1, addr: 32'h8000});
        tick();
        m1_req_i = 0; data_gnt_i = 0; rst_i = 1;
        tick();
        rst_i = 0; data_rvalid_i = 1; data_rdata_i = 32'h777;
        #3 chk("t6_post_rst_req", {31'd0, data_req_o}, 0);
        chk("t6_post_rst_gnt", {30'd0, m1_gnt_o, m0_gnt_o}, 0);
        chk("t6_post_rst_rvalid", {30'd0, m1_rvalid_o, m0_rvalid_o}, 0);
        chk("t6_post_rst_addr", data_addr_o, 0);
        tick();
        data_rvalid_i = 0;
        m0_req_i = 1; m0_addr_i = 32'h9000; m1_req_i = 1; m1_addr_i = 32'h9100;
        tick();
        data_gnt_i = 1;
        gnt_q.push_back('{port: 1'b0, addr: 32'h9000});
        tick();
        m0_req_i = 0; m1_req_i = 0; data_gnt_i = 0;
        data_rvalid_i = 1; data_rdata_i = 32'hCAFE;
        rsp_q.push_back('{port: 1'b0, data: 32'hCAFE, err: 1'b0});
        tick();
        data_rvalid_i = 0;
        tick();
        tick();

        // Every expected grant/response must have been seen.
        chk("gnt_queue_drained", gnt_q.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
